pc_gen: RTL and testbench

Parametrised program-counter generator for the IF stage, successor to the single-PC register.
- Arbitrates NUM_RDR prioritised redirect channels (e.g. ch0 = EX branch, ch1 = ID jump).
- Latches a redirect that arrives during a freeze instead of dropping it.
- Advances by FETCH_BYTES only when fetch accepts the current PC.

---
 rtl/pc_gen_if.sv | 30 +++
 rtl/pc_gen.sv | 135 +++++++++++++
 tb/tb_pc_gen.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Fetch-side bundle for pc_gen: freeze/fetch handshake, redirect channels and PC outputs.
// The slave modport is the pc_gen side; the master modport is the pipeline driving it.
interface pc_gen_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned NUM_RDR = 2
);
    localparam int unsigned CH_W = (NUM_RDR > 1) ? $clog2(NUM_RDR) : 1;

    logic                      freeze_i;
    logic                      fetch_ready_i;
    logic [NUM_RDR-1:0]        rdr_valid_i;
    logic [NUM_RDR*ADDR_W-1:0] rdr_target_i;
    logic [ADDR_W-1:0]         pc_o;
    logic                      pc_valid_o;
    logic                      flush_o;
    logic [CH_W-1:0]           flush_ch_o;
    logic                      pend_o;
    logic                      misalign_o;
    logic [ADDR_W-1:0]         misalign_addr_o;

    modport master (
        output freeze_i, fetch_ready_i, rdr_valid_i, rdr_target_i,
        input  pc_o, pc_valid_o, flush_o, flush_ch_o, pend_o, misalign_o, misalign_addr_o
    );

    modport slave (
        input  freeze_i, fetch_ready_i, rdr_valid_i, rdr_target_i,
        output pc_o, pc_valid_o, flush_o, flush_ch_o, pend_o, misalign_o, misalign_addr_o
    );
endinterface

// File: rtl/pc_gen.sv
// IF-stage program-counter generator with prioritised redirects and a freeze-time pending slot.
// Optional target alignment check enabled by defining PC_GEN_MISALIGN_CHECK_EN.
module pc_gen #(
    parameter int unsigned      ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned      NUM_RDR     = 2,
    parameter int unsigned      FETCH_BYTES = 4,
    parameter int unsigned      ALIGN_LSB   = 2
) (
    input logic     clk,
    input logic     rst,
    pc_gen_if.slave bus
);
    localparam int unsigned CH_W = (NUM_RDR > 1) ? $clog2(NUM_RDR) : 1;

    if (ALIGN_LSB >= ADDR_W) begin : g_bad_align
        $error("pc_gen: ALIGN_LSB must be smaller than ADDR_W");
    end
    if ((FETCH_BYTES == 0) || ((FETCH_BYTES & (FETCH_BYTES - 1)) != 0)) begin : g_bad_step
        $error("pc_gen: FETCH_BYTES must be a power of two");
    end

    logic [ADDR_W-1:0] pc_q;
    logic              pc_valid_q;
    logic              flush_q;
    logic [CH_W-1:0]   flush_ch_q;

    logic              pend_vld_q;
    logic [CH_W-1:0]   pend_ch_q;
    logic [ADDR_W-1:0] pend_tgt_q;

    logic              new_vld;
    logic [CH_W-1:0]   new_ch;
    logic [ADDR_W-1:0] new_tgt;

    logic              eff_vld;
    logic [CH_W-1:0]   eff_ch;
    logic [ADDR_W-1:0] eff_tgt;

    // Lowest-index requesting channel wins this cycle.
    always_comb begin
        new_vld = 1'b0;
        new_ch  = '0;
        new_tgt = '0;
        for (int unsigned k = 0; k < NUM_RDR; k++) begin
            if (!new_vld && bus.rdr_valid_i[k]) begin
                new_vld = 1'b1;
                new_ch  = CH_W'(k);
                new_tgt = bus.rdr_target_i[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // A new request displaces the pending one when its channel is at least as urgent.
    always_comb begin
        if (new_vld && (!pend_vld_q || (new_ch <= pend_ch_q))) begin
            eff_vld = 1'b1;
            eff_ch  = new_ch;
            eff_tgt = new_tgt;
        end else begin
            eff_vld = pend_vld_q;
            eff_ch  = pend_ch_q;
            eff_tgt = pend_tgt_q;
        end
    end

`ifdef PC_GEN_MISALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] LOW_MASK = (ADDR_W'(1) << ALIGN_LSB) - ADDR_W'(1);

    logic              mis_q;
    logic [ADDR_W-1:0] mis_addr_q;
    logic              eff_bad;

    assign eff_bad = |(eff_tgt & LOW_MASK);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            flush_ch_q <= '0;
            pend_vld_q <= 1'b0;
            pend_ch_q  <= '0;
            pend_tgt_q <= '0;
`ifdef PC_GEN_MISALIGN_CHECK_EN
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
`endif
        end else begin
            pc_valid_q <= 1'b1;
            flush_q    <= 1'b0;
`ifdef PC_GEN_MISALIGN_CHECK_EN
            mis_q      <= 1'b0;
`endif
            if (bus.freeze_i) begin
                if (eff_vld) begin
                    pend_vld_q <= 1'b1;
                    pend_ch_q  <= eff_ch;
                    pend_tgt_q <= eff_tgt;
                end
            end else if (eff_vld) begin
                pend_vld_q <= 1'b0;
                flush_q    <= 1'b1;
                flush_ch_q <= eff_ch;
`ifdef PC_GEN_MISALIGN_CHECK_EN
                if (eff_bad) begin
                    pc_q       <= eff_tgt & ~LOW_MASK;
                    mis_q      <= 1'b1;
                    mis_addr_q <= eff_tgt;
                end else begin
                    pc_q <= eff_tgt;
                end
`else
                pc_q <= eff_tgt;
`endif
            end else if (bus.fetch_ready_i && pc_valid_q) begin
                pc_q <= pc_q + ADDR_W'(FETCH_BYTES);
            end
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.pc_valid_o = pc_valid_q;
    assign bus.flush_o    = flush_q;
    assign bus.flush_ch_o = flush_ch_q;
    assign bus.pend_o     = pend_vld_q;
`ifdef PC_GEN_MISALIGN_CHECK_EN
    assign bus.misalign_o      = mis_q;
    assign bus.misalign_addr_o = mis_addr_q;
`else
    assign bus.misalign_o      = 1'b0;
    assign bus.misalign_addr_o = '0;
`endif
endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_pc_gen;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned NR     = 2;
    localparam logic [31:0] RPC    = 32'h100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_gen_if #(.ADDR_W(ADDR_W), .NUM_RDR(NR)) bus ();

    pc_gen #(
        .ADDR_W(ADDR_W), .RESET_PC(RPC), .NUM_RDR(NR), .FETCH_BYTES(4), .ALIGN_LSB(2)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Behavioural model state.
    logic [31:0] m_pc = RPC;
    bit          m_valid = 1'b0;
    bit          m_flush = 1'b0;
    int          m_ch = 0;
    bit          m_pend = 1'b0;
    int          m_pend_ch = 0;
    logic [31:0] m_pend_tgt = '0;
    bit          m_mis = 1'b0;
    logic [31:0] m_mis_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        int          best_ch;
        logic [31:0] best_tgt;
        bit          have;
        logic [31:0] t;
        if (rst) begin
            m_pc = RPC; m_valid = 0; m_flush = 0; m_ch = 0;
            m_pend = 0; m_mis = 0; m_mis_addr = '0;
        end else begin
            have = m_pend; best_ch = m_pend_ch; best_tgt = m_pend_tgt;
            for (int k = NR - 1; k >= 0; k--) begin
                if (bus.rdr_valid_i[k] && (!have || k <= best_ch)) begin
                    have = 1; best_ch = k;
                    best_tgt = bus.rdr_target_i[k*ADDR_W +: ADDR_W];
                end
            end
            // the loop above scans high-to-low so the lowest requester is the last to win
            m_flush = 0; m_mis = 0;
            if (bus.freeze_i) begin
                if (have) begin m_pend = 1; m_pend_ch = best_ch; m_pend_tgt = best_tgt; end
            end else if (have) begin
                m_pend = 0; m_flush = 1; m_ch = best_ch;
                t = best_tgt;
`ifdef PC_GEN_MISALIGN_CHECK_EN
                if (t % 4 != 0) begin m_mis = 1; m_mis_addr = t; t = t - (t % 4); end
`endif
                m_pc = t;
            end else if (bus.fetch_ready_i && m_valid) begin
                m_pc = m_pc + 32'd4;
            end
            m_valid = 1;
        end
        chk_en <= 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", bus.pc_o, m_pc);
            chk("pc_valid", 32'(bus.pc_valid_o), 32'(m_valid));
            chk("flush", 32'(bus.flush_o), 32'(m_flush));
            if (m_flush) chk("flush_ch", 32'(bus.flush_ch_o), 32'(m_ch));
            chk("pend", 32'(bus.pend_o), 32'(m_pend));
            chk("misalign", 32'(bus.misalign_o), 32'(m_mis));
            chk("misalign_addr", bus.misalign_addr_o, m_mis_addr);
        end
    end

    task automatic cyc(input bit fz, input bit rdy, input logic [1:0] v,
                       input logic [31:0] t0, input logic [31:0] t1);
        bus.freeze_i      = fz;
        bus.fetch_ready_i = rdy;
        bus.rdr_valid_i   = v;
        bus.rdr_target_i  = {t1, t0};
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ta, tb;
        bus.freeze_i = 0; bus.fetch_ready_i = 0; bus.rdr_valid_i = '0; bus.rdr_target_i = '0;
        rst = 1;
        cyc(0, 1, 2'b00, 0, 0);
        cyc(0, 1, 2'b00, 0, 0);
        chk("lit_rst_pc", bus.pc_o, 32'h100);
        chk("lit_rst_valid", 32'(bus.pc_valid_o), 32'd0);
        chk("lit_rst_pend", 32'(bus.pend_o), 32'd0);
        rst = 0;
        cyc(0, 1, 2'b00, 0, 0);
        chk("lit_valid_rise", 32'(bus.pc_valid_o), 32'd1);
        chk("lit_pc_hold_first", bus.pc_o, 32'h100);
        cyc(0, 1, 2'b00, 0, 0); chk("lit_inc1", bus.pc_o, 32'h104);
        cyc(0, 1, 2'b00, 0, 0); chk("lit_inc2", bus.pc_o, 32'h108);
        cyc(0, 1, 2'b00, 0, 0); chk("lit_inc3", bus.pc_o, 32'h10C);

        cyc(0, 1, 2'b01, 32'h0, 0);
        chk("lit_rdr0_pc", bus.pc_o, 32'h0);
        cyc(0, 1, 2'b00, 0, 0); chk("lit_rdy_a", bus.pc_o, 32'h4);
        chk("lit_noflush", 32'(bus.flush_o), 32'd0);
        cyc(0, 0, 2'b00, 0, 0); chk("lit_rdy_b", bus.pc_o, 32'h4);
        cyc(0, 1, 2'b00, 0, 0); chk("lit_rdy_c", bus.pc_o, 32'h8);

        cyc(0, 1, 2'b11, 32'h2000, 32'h3000);
        chk("lit_prio_pc", bus.pc_o, 32'h2000);
        chk("lit_prio_flush", 32'(bus.flush_o), 32'd1);
        chk("lit_prio_ch", 32'(bus.flush_ch_o), 32'd0);

        cyc(1, 1, 2'b10, 0, 32'h500);
        chk("lit_frz_hold", bus.pc_o, 32'h2000);
        chk("lit_frz_pend", 32'(bus.pend_o), 32'd1);
        cyc(1, 1, 2'b01, 32'h600, 0);
        cyc(1, 1, 2'b00, 0, 0);
        chk("lit_frz_hold3", bus.pc_o, 32'h2000);
        cyc(0, 1, 2'b00, 0, 0);
        chk("lit_unfrz_pc", bus.pc_o, 32'h600);
        chk("lit_unfrz_pend", 32'(bus.pend_o), 32'd0);

        cyc(1, 0, 2'b01, 32'h700, 0);
        cyc(1, 0, 2'b10, 0, 32'h800);
        cyc(0, 0, 2'b00, 0, 0);
        chk("lit_keep_ch0", bus.pc_o, 32'h700);

        cyc(1, 0, 2'b10, 0, 32'h500);
        cyc(1, 0, 2'b10, 0, 32'h900);
        cyc(0, 0, 2'b00, 0, 0);
        chk("lit_same_ch_newer", bus.pc_o, 32'h900);

        cyc(0, 0, 2'b01, 32'hFFFF_FFFC, 0);
        cyc(0, 1, 2'b00, 0, 0);
        chk("lit_wrap", bus.pc_o, 32'h0);

        cyc(0, 0, 2'b01, 32'h1002, 0);
`ifdef PC_GEN_MISALIGN_CHECK_EN
        chk("lit_mis_pc", bus.pc_o, 32'h1000);
        chk("lit_mis_flag", 32'(bus.misalign_o), 32'd1);
        chk("lit_mis_addr", bus.misalign_addr_o, 32'h1002);
`else
        chk("lit_mis_pc", bus.pc_o, 32'h1002);
        chk("lit_mis_flag", 32'(bus.misalign_o), 32'd0);
`endif

        cyc(1, 0, 2'b01, 32'hAAA8, 0);
        rst = 1;
        cyc(1, 0, 2'b00, 0, 0);
        chk("lit_rst_discard", 32'(bus.pend_o), 32'd0);
        rst = 0;
        cyc(0, 0, 2'b00, 0, 0);
        chk("lit_rst_discard_pc", bus.pc_o, 32'h100);

        for (int i = 0; i < 3000; i++) begin
            ta = $urandom; tb = $urandom;
            if ($urandom_range(0, 7) != 0) begin ta[1:0] = 2'b00; tb[1:0] = 2'b00; end
            if ($urandom_range(0, 15) == 0) ta = 32'hFFFF_FFF0 | (ta & 32'hC);
            rst = ($urandom_range(0, 99) == 0);
            cyc($urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
                ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00, ta, tb);
        end
        rst = 0;
        cyc(0, 0, 2'b00, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
